// File: rtl/high_level_pkg.sv
// -----------------------------------------------------------------------------
// high_level_pkg
//   Shared types and constants for the auto_pq priority-queue demonstrator.
//   - state_t        : top-level FSM states
//   - KEY_W_DEF      : default key width
//   - LFSR_TAPS      : tap mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   - LFSR_SEED_DEF  : LFSR value after reset (nonzero)
//   - lfsr_next()    : one left-shift step with XOR feedback into bit 0
// -----------------------------------------------------------------------------
package high_level_pkg;

  localparam int          KEY_W_DEF     = 16;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADD,
    REMOVE,
    DISPLAY
  } state_t;

  // Maximal-length polynomial, so a nonzero seed never reaches zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/high_level_pq_sorted.sv
// -----------------------------------------------------------------------------
// pq_sorted
//   Min-priority queue kept as an ascending sorted register array; entry 0 is
//   always the minimum. Insert is a single-cycle compare-and-shift, remove-min
//   is a single-cycle shift toward the head.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset (count only)
//     i_clear       empty the queue
//     i_insert      insert i_key (ignored when full)
//     i_remove      drop the head entry (ignored when empty)
//     i_key         key to insert
//     o_min_key     current head (smallest key)
//     o_count       number of valid entries
//     o_full        o_count == DEPTH
//     o_empty       o_count == 0
// -----------------------------------------------------------------------------
module pq_sorted #(
  parameter  int DEPTH = 16,
  parameter  int KEY_W = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_insert,
  input  logic             i_remove,
  input  logic [KEY_W-1:0] i_key,
  output logic [KEY_W-1:0] o_min_key,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [KEY_W-1:0] r_keys      [DEPTH];
  logic [KEY_W-1:0] w_next_keys [DEPTH];
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] w_gt;
  logic             w_do_ins;
  logic             w_do_rem;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_min_key = r_keys[0];

  // Insert takes priority; the controller never requests both at once.
  assign w_do_ins = i_insert && !o_full;
  assign w_do_rem = i_remove && !o_empty && !w_do_ins;

  // w_gt[i]: slot i must move up (or receive the key). Empty slots count as
  // "greater", and equal keys stay below the new one so duplicates are kept.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      w_gt[i] = (CW'(i) >= r_count) || (r_keys[i] > i_key);
  end

  // NOTE: every always_comb output gets a full default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_next_keys = r_keys;
    if (w_do_ins) begin
      if (w_gt[0]) w_next_keys[0] = i_key;
      for (int i = 1; i < DEPTH; i++)
        if (w_gt[i]) w_next_keys[i] = w_gt[i-1] ? r_keys[i-1] : i_key;
    end else if (w_do_rem) begin
      for (int i = 0; i < DEPTH - 1; i++)
        w_next_keys[i] = r_keys[i+1];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_count <= '0;
    else if (i_clear)      r_count <= '0;
    else if (w_do_ins)     r_count <= r_count + 1'b1;
    else if (w_do_rem)     r_count <= r_count - 1'b1;
  end

  // NOTE: the key storage has no reset; r_count alone defines which entries are valid, so resetting it is enough.
  always_ff @(posedge clk) begin
    r_keys <= w_next_keys;
  end

endmodule

// File: rtl/high_level.sv
// -----------------------------------------------------------------------------
// high_level
//   Self-running priority-queue demonstrator. On start it fills pq_sorted with
//   DEPTH LFSR keys, then removes them smallest-first, holding each removed key
//   for DISPLAY_CYCLES clocks on the byte and colour outputs.
//   Ports:
//     clk, rst                  clock, asynchronous active-high reset
//     start                     run enable (sampled in IDLE and at batch end)
//     data1 / data2             displayed key [15:8] / [7:0]
//     red / green / blue        displayed key [15:13] / [12:10] / [9:7]
//     sigIDLE..sigDISPLAY       one-hot decode of the FSM state
//     sigFULL / sigEMPTY        queue full / empty
// -----------------------------------------------------------------------------
module high_level
  import high_level_pkg::*;
#(
  parameter int          DEPTH          = 16,
  parameter int          KEY_W          = KEY_W_DEF,
  parameter int          DISPLAY_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED      = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [2:0] blue,
  output logic       sigIDLE,
  output logic       sigSTART,
  output logic       sigADD,
  output logic       sigREMOVE,
  output logic       sigDISPLAY,
  output logic       sigFULL,
  output logic       sigEMPTY
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = $clog2(DISPLAY_CYCLES + 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [15:0]      r_lfsr;
  logic [KEY_W-1:0] r_disp;
  logic [HW-1:0]    r_hold;
  logic             w_hold_done;
  logic             w_clear;
  logic             w_insert;
  logic             w_remove;
  logic [KEY_W-1:0] w_min_key;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;

  pq_sorted #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W)
  ) u_pq (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_insert  (w_insert),
    .i_remove  (w_remove),
    .i_key     (KEY_W'(r_lfsr)),
    .o_min_key (w_min_key),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_hold_done = (r_hold == HW'(DISPLAY_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_insert     = 1'b0;
    w_remove     = 1'b0;
    unique case (r_state)
      IDLE:    if (start) w_next_state = START;
      START: begin
        w_clear      = 1'b1;
        w_next_state = ADD;
      end
      ADD: begin
        w_insert = 1'b1;
        // Leave after the insert that makes the queue full.
        if (w_count == CW'(DEPTH - 1)) w_next_state = REMOVE;
      end
      REMOVE: begin
        w_remove     = 1'b1;
        w_next_state = DISPLAY;
      end
      DISPLAY: begin
        if (w_hold_done) begin
          if (!w_empty)   w_next_state = REMOVE;
          else if (start) w_next_state = START;
          else            w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The LFSR advances only while inserting, so the inserted key is the
  // pre-advance value and consecutive batches continue the same sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
      r_disp <= '0;
      r_hold <= '0;
    end else begin
      if (r_state == ADD)      r_lfsr <= lfsr_next(r_lfsr);
      if (w_remove && !w_empty) r_disp <= w_min_key;
      r_hold <= (r_state == DISPLAY) ? r_hold + 1'b1 : '0;
    end
  end

  assign data1 = r_disp[KEY_W-1 -: 8];
  assign data2 = r_disp[7:0];
  assign red   = r_disp[KEY_W-1 -: 3];
  assign green = r_disp[KEY_W-4 -: 3];
  assign blue  = r_disp[KEY_W-7 -: 3];

  assign sigIDLE    = (r_state == IDLE);
  assign sigSTART   = (r_state == START);
  assign sigADD     = (r_state == ADD);
  assign sigREMOVE  = (r_state == REMOVE);
  assign sigDISPLAY = (r_state == DISPLAY);
  assign sigFULL    = w_full;
  assign sigEMPTY   = w_empty;

endmodule

// File: tb/tb_high_level.sv
// -----------------------------------------------------------------------------
// tb_high_level
//   Directed bench for high_level. An independent LFSR model generates each
//   batch's keys, sorts them and pushes them to a scoreboard queue when the
//   batch is started; every REMOVE pops one and compares it with the display.
// -----------------------------------------------------------------------------
module tb_high_level;

  localparam int DEPTH = 16;
  localparam int DCYC  = 64;
  // START + DEPTH ADD + DEPTH*(REMOVE + DISPLAY): counting the first START as
  // cycle 1, the next START lands on cycle 1058.
  localparam int BATCH_GAP = 1 + DEPTH + DEPTH * (1 + DCYC);

  localparam logic [4:0] M_IDLE = 5'b10000;
  localparam logic [4:0] M_STRT = 5'b01000;
  localparam logic [4:0] M_ADD  = 5'b00100;
  localparam logic [4:0] M_REM  = 5'b00010;
  localparam logic [4:0] M_DISP = 5'b00001;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data1, data2;
  logic [2:0] red, green, blue;
  logic       sigIDLE, sigSTART, sigADD, sigREMOVE, sigDISPLAY, sigFULL, sigEMPTY;

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  logic [15:0] m_lfsr;
  logic [15:0] sb[$];

  high_level dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data1      (data1),
    .data2      (data2),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .sigIDLE    (sigIDLE),
    .sigSTART   (sigSTART),
    .sigADD     (sigADD),
    .sigREMOVE  (sigREMOVE),
    .sigDISPLAY (sigDISPLAY),
    .sigFULL    (sigFULL),
    .sigEMPTY   (sigEMPTY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  function automatic logic [15:0] model_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [4:0] flags();
    return {sigIDLE, sigSTART, sigADD, sigREMOVE, sigDISPLAY};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input string tag, input logic [4:0] mask, input int budget);
    int n = 0;
    while (flags() !== mask && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(flags()), 32'(mask));
  endtask

  // Next DEPTH model keys in insertion order, sorted ascending, onto the scoreboard.
  task automatic push_batch();
    logic [15:0] k[DEPTH];
    logic [15:0] t;
    for (int i = 0; i < DEPTH; i++) begin
      k[i]   = m_lfsr;
      m_lfsr = model_next(m_lfsr);
    end
    for (int i = 1; i < DEPTH; i++)
      for (int j = i; j > 0 && k[j-1] > k[j]; j--) begin
        t = k[j]; k[j] = k[j-1]; k[j-1] = t;
      end
    for (int i = 0; i < DEPTH; i++) sb.push_back(k[i]);
  endtask

  // Expects the DUT to be in (or about to enter) START.
  task automatic fill(input bit drop_start, output int t_start);
    int n = 0;
    push_batch();
    wait_for("start_state", M_STRT, 4);
    t_start = cyc;
    tick();
    while (sigADD === 1'b1 && n < 40) begin
      if (drop_start && n == 3) start = 1'b0;
      n++;
      tick();
    end
    check("add_cycles", n, DEPTH);
    check("remove_after_add", 32'(flags()), 32'(M_REM));
    check("full_after_add", 32'(sigFULL), 32'd1);
  endtask

  // One REMOVE → DISPLAY step; leaves the bench in the first DISPLAY cycle.
  task automatic show_one(inout logic [15:0] prev, input bit first);
    logic [15:0] exp;
    logic [15:0] got;
    wait_for("remove_state", M_REM, 2);
    tick();
    check("display_state", 32'(flags()), 32'(M_DISP));
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {data1, data2};
      check("key", 32'(got), 32'(exp));
      check("rgb", 32'({red, green, blue}), 32'({exp[15:13], exp[12:10], exp[9:7]}));
      check("empty_flag", 32'(sigEMPTY), 32'(sb.size() == 0));
      if (!first) check("nondecreasing", 32'(got >= prev), 32'd1);
      prev = got;
    end
  endtask

  task automatic drain(input int nkeys);
    logic [15:0] prev = '0;
    int n;
    for (int k = 0; k < nkeys; k++) begin
      show_one(prev, k == 0);
      n = 0;
      while (sigDISPLAY === 1'b1 && n < 200) begin
        n++;
        tick();
      end
      check("hold_cycles", n, DCYC);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, 32'({flags(), sigFULL, sigEMPTY}), 32'({M_IDLE, 2'b01}));
    check({tag, "_data"}, 32'({data1, data2}), 32'd0);
    check({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
  endtask

  initial begin
    int          t0, t1;
    logic [15:0] prev = '0;

    rst    = 1'b1;
    start  = 1'b0;
    m_lfsr = 16'hACE1;
    tick();
    check_reset_outputs("reset");

    // Batch 1: start held high; first batch must be the sorted first 16 keys.
    rst   = 1'b0;
    start = 1'b1;
    fill(1'b0, t0);
    drain(DEPTH);
    check("batch1_next_start", 32'(flags()), 32'(M_STRT));
    t1 = cyc;
    check("batch_gap", t1 - t0, BATCH_GAP);

    // Batch 2: start dropped during ADD; continued LFSR keys, then IDLE.
    fill(1'b1, t0);
    drain(DEPTH);
    check("idle_after_stop", 32'(flags()), 32'(M_IDLE));
    tick();
    tick();
    check("idle_holds", 32'({flags(), sigEMPTY}), 32'({M_IDLE, 1'b1}));

    // Batch 3: restart, then reset in DISPLAY with 7 keys still queued.
    start = 1'b1;
    fill(1'b0, t0);
    drain(8);
    show_one(prev, 1'b1);
    repeat (10) tick();
    check("pre_reset_display", 32'({flags(), sigEMPTY}), 32'({M_DISP, 1'b0}));
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset_async");
    tick();
    check_reset_outputs("midreset_held");

    // Batch 4: after reset the first batch is reproduced exactly.
    sb.delete();
    m_lfsr = 16'hACE1;
    rst    = 1'b0;
    fill(1'b0, t0);
    start = 1'b0;
    drain(DEPTH);
    check("idle_final", 32'(flags()), 32'(M_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
